mm_feed_ctrl: RTL and testbench

MM_FEED_CTRL -- requirements
Module: mm_feed_ctrl

---
 rtl/mm_feed_ctrl_if.sv | 33 +++
 rtl/mm_feed_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mm_feed_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_feed_ctrl_if.sv
// Bus bundle between mm_feed_ctrl and its host / 4x4 systolic array.
// The slave modport is the controller's view; master is the host/array side.
interface mm_feed_ctrl_if #(
   parameter int DW = 8,
   parameter int CW = 17
);
   logic             ld_valid;
   logic             ld_ready;
   logic             ld_sel;
   logic [3:0]       ld_idx;
   logic [DW-1:0]    ld_data;
   logic             start;
   logic             busy;
   logic             done;
   logic             sa_clr;
   logic [4*DW-1:0]  a_out;
   logic [4*DW-1:0]  b_out;
   logic [16*CW-1:0] sa_c;
   logic             res_valid;
   logic             res_ready;
   logic [CW-1:0]    res_data;
   logic [3:0]       res_idx;

   modport slave (
      input  ld_valid, ld_sel, ld_idx, ld_data, start, sa_c, res_ready,
      output ld_ready, busy, done, sa_clr, a_out, b_out, res_valid, res_data, res_idx
   );

   modport master (
      output ld_valid, ld_sel, ld_idx, ld_data, start, sa_c, res_ready,
      input  ld_ready, busy, done, sa_clr, a_out, b_out, res_valid, res_data, res_idx
   );
endinterface

// File: rtl/mm_feed_ctrl.sv
// Operand store, skewed feed, drain/capture and result streaming for a 4x4 systolic array.
// Optional MM_FEED_CTRL_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module mm_feed_ctrl #(
   parameter int DW        = 8,
   parameter int CW        = 17,
   parameter int DRAIN_CYC = 4
) (
   input  logic          clk,
   input  logic          reset,
   mm_feed_ctrl_if.slave bus
`ifdef MM_FEED_CTRL_PERF_EN
   ,
   output logic [15:0]   perf_cycles
`endif
);

   localparam logic [7:0] FEED_LAST  = 8'd6;
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [DW-1:0]   r_mat_a [16];
   logic [DW-1:0]   r_mat_b [16];
   logic [CW-1:0]   r_cap   [16];
   logic [7:0]      r_cnt;
   logic [3:0]      r_ridx;
   logic            r_done;
   logic            w_ld_fire;
   logic            w_start_fire;
   logic            w_capture;
   logic            w_res_fire;
   logic            w_busy;
   logic [4*DW-1:0] w_a_out;
   logic [4*DW-1:0] w_b_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_start_fire = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next       = S_CLEAR;
               w_start_fire = 1'b1;
            end
         end
         S_CLEAR: w_next = S_FEED;
         S_FEED: begin
            if (r_cnt == FEED_LAST) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_cnt == DRAIN_LAST) begin
               w_next    = S_OUT;
               w_capture = 1'b1;
            end
         end
         S_OUT: begin
            if (bus.res_ready && (r_ridx == 4'd15)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_ld_fire  = bus.ld_valid & bus.ld_ready;
   assign w_res_fire = (r_state == S_OUT) & bus.res_ready;
   assign w_busy     = (r_state != S_IDLE);

   // Shared beat counter: restarts on every state change, counts in FEED and DRAIN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_next != r_state) begin
         r_cnt <= '0;
      end else if ((r_state == S_FEED) || (r_state == S_DRAIN)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ridx <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_res_fire && (r_ridx == 4'd15);
         if (w_res_fire) r_ridx <= r_ridx + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned n = 0; n < 16; n++) begin
            r_mat_a[n] <= '0;
            r_mat_b[n] <= '0;
         end
      end else if (w_ld_fire) begin
         if (bus.ld_sel) r_mat_b[bus.ld_idx] <= bus.ld_data;
         else            r_mat_a[bus.ld_idx] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned n = 0; n < 16; n++) r_cap[n] <= '0;
      end else if (w_capture) begin
         for (int unsigned n = 0; n < 16; n++) r_cap[n] <= bus.sa_c[n*CW +: CW];
      end
   end

   // Lane L carries A[L][t-L] and B[t-L][L]; both use the same skewed column/row k.
   always_comb begin : p_lanes
      logic [3:0] k;
      k       = '0;
      w_a_out = '0;
      w_b_out = '0;
      if (r_state == S_FEED) begin
         for (int unsigned i = 0; i < 4; i++) begin
            k = r_cnt[3:0] - 4'(i);
            if ((r_cnt[3:0] >= 4'(i)) && (k <= 4'd3)) begin
               w_a_out[i*DW +: DW] = r_mat_a[{2'(i), k[1:0]}];
               w_b_out[i*DW +: DW] = r_mat_b[{k[1:0], 2'(i)}];
            end
         end
      end
   end

   // ld_ready and sa_clr are gated by reset so they reach reset values without a clock.
   assign bus.ld_ready  = (r_state == S_IDLE) & reset;
   assign bus.sa_clr    = (r_state == S_CLEAR) | ~reset;
   assign bus.busy      = w_busy;
   assign bus.done      = r_done;
   assign bus.a_out     = w_a_out;
   assign bus.b_out     = w_b_out;
   assign bus.res_valid = (r_state == S_OUT);
   assign bus.res_idx   = r_ridx;
   assign bus.res_data  = r_cap[r_ridx];

`ifdef MM_FEED_CTRL_PERF_EN
   logic [15:0] r_perf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perf <= '0;
      end else if (w_start_fire) begin
         r_perf <= '0;
      end else if (w_busy && (r_perf != '1)) begin
         r_perf <= r_perf + 16'd1;
      end
   end

   assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_mm_feed_ctrl.sv
// Directed bench for mm_feed_ctrl with a behavioural 4x4 output-stationary array attached.
module tb_mm_feed_ctrl;

   localparam int DW = 8;
   localparam int CW = 17;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errs = 0;
   int   checks = 0;
   logic [31:0] expc [16];
   logic [31:0] got_first;
   logic [31:0] got_last;

   int A_m [4][4] = '{'{7, 1, 9, 5}, '{5, 8, 4, 3}, '{8, 2, 3, 7}, '{0, 6, 8, 9}};
   // B_m[k][j]: row k of B, built from the given columns
   int B_m [4][4] = '{'{5, 0, 3, 1}, '{2, 6, 8, 8}, '{6, 2, 1, 5}, '{1, 0, 4, 6}};

   mm_feed_ctrl_if #(.DW(DW), .CW(CW)) bus ();

`ifdef MM_FEED_CTRL_PERF_EN
   logic [15:0] perf;
`endif

   mm_feed_ctrl #(.DW(DW), .CW(CW), .DRAIN_CYC(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MM_FEED_CTRL_PERF_EN
      ,
      .perf_cycles (perf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural systolic array: a moves right, b moves down, c accumulates.
   logic [DW-1:0] pa  [16];
   logic [DW-1:0] pb  [16];
   logic [CW-1:0] pc  [16];
   logic [DW-1:0] ain [16];
   logic [DW-1:0] bin [16];

   always_comb begin
      for (int n = 0; n < 16; n++) begin
         ain[n] = ((n % 4) == 0) ? bus.a_out[(n/4)*DW +: DW] : pa[n-1];
         bin[n] = (n < 4)        ? bus.b_out[n*DW +: DW]     : pb[n-4];
      end
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < 16; n++) begin
         if (bus.sa_clr) begin
            pa[n] <= '0;
            pb[n] <= '0;
            pc[n] <= '0;
         end else begin
            pa[n] <= ain[n];
            pb[n] <= bin[n];
            pc[n] <= pc[n] + CW'(ain[n]) * CW'(bin[n]);
         end
      end
   end

   always_comb begin
      for (int n = 0; n < 16; n++) bus.sa_c[n*CW +: CW] = pc[n];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input int l1, input int l2, input int l3, input int l4);
      return {8'(l4), 8'(l3), 8'(l2), 8'(l1)};
   endfunction

   task automatic put(input logic sel, input int idx, input int d);
      bus.ld_valid = 1'b1;
      bus.ld_sel   = sel;
      bus.ld_idx   = 4'(idx);
      bus.ld_data  = DW'(d);
      @(negedge clk);
      bus.ld_valid = 1'b0;
   endtask

   // B[3][3] is left out: it is written in the same cycle as start.
   task automatic load_all();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) put(1'b0, i*4 + k, A_m[i][k]);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++)
            if (!(k == 3 && j == 3)) put(1'b1, k*4 + j, B_m[k][j]);
   endtask

   task automatic collect(input int stall_r, input bit poke, input int acc, input int exp_lat);
      int r;
      int guard;
      bit seen;
      int stall_left;
      r = 0;
      guard = 0;
      seen = 1'b0;
      stall_left = 5;
      while (!seen && guard < 80) begin
         @(negedge clk);
         guard++;
         bus.ld_valid = 1'b0;
         if (bus.done) begin
            seen = 1'b1;
            chk("latency", 32'(cyc - acc), 32'(exp_lat));
            chk("done_busy", 32'(bus.busy), 32'd0);
            chk("n_results", 32'(r), 32'd16);
         end else if (bus.res_valid) begin
            chk("res_idx", 32'(bus.res_idx), 32'(r));
            chk("res_data", 32'(bus.res_data), expc[r % 16]);
            if (r == 0)  got_first = 32'(bus.res_data);
            if (r == 15) got_last  = 32'(bus.res_data);
            if (poke && r == 3) begin
               chk("ld_ready_out", 32'(bus.ld_ready), 32'd0);
               bus.ld_valid = 1'b1;
               bus.ld_sel   = 1'b0;
               bus.ld_idx   = 4'd0;
               bus.ld_data  = 8'd99;
            end
            if (r == stall_r && stall_left > 0) begin
               bus.res_ready = 1'b0;
               stall_left--;
            end else begin
               bus.res_ready = 1'b1;
               r++;
            end
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(bus.done), 32'd0);
      chk("idle_ld_ready", 32'(bus.ld_ready), 32'd1);
   endtask

   task automatic run(input int stall_r, input bit poke, input bit abort_t3, input int exp_lat);
      int acc;
      bus.ld_valid = 1'b1;
      bus.ld_sel   = 1'b1;
      bus.ld_idx   = 4'd15;
      bus.ld_data  = DW'(B_m[3][3]);
      bus.start    = 1'b1;
      acc = cyc + 1;  // edge count at which start is accepted
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.start    = 1'b0;
      chk("clr_sa_clr", 32'(bus.sa_clr), 32'd1);
      chk("clr_a", 32'(bus.a_out), 32'd0);
      chk("clr_b", 32'(bus.b_out), 32'd0);
      chk("clr_busy", 32'(bus.busy), 32'd1);
      chk("clr_ld_ready", 32'(bus.ld_ready), 32'd0);
      @(negedge clk);
      chk("t0_a", 32'(bus.a_out), lanes(7, 0, 0, 0));
      chk("t0_b", 32'(bus.b_out), lanes(5, 0, 0, 0));
      chk("t0_sa_clr", 32'(bus.sa_clr), 32'd0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_a", 32'(bus.a_out), lanes(5, 4, 2, 0));
      chk("t3_b", 32'(bus.b_out), lanes(1, 2, 8, 1));
      if (abort_t3) begin
         reset = 1'b0;
         #1;
         chk("abort_a", 32'(bus.a_out), 32'd0);
         chk("abort_b", 32'(bus.b_out), 32'd0);
         chk("abort_sa_clr", 32'(bus.sa_clr), 32'd1);
         chk("abort_busy", 32'(bus.busy), 32'd0);
         chk("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
         chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
         @(negedge clk);
         @(negedge clk);
         reset = 1'b1;
         #1;
         chk("rel_ld_ready", 32'(bus.ld_ready), 32'd1);
         chk("rel_sa_clr", 32'(bus.sa_clr), 32'd0);
         chk("rel_busy", 32'(bus.busy), 32'd0);
         @(negedge clk);
      end else begin
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
         chk("t6_a", 32'(bus.a_out), lanes(0, 0, 0, 9));
         chk("t6_b", 32'(bus.b_out), lanes(0, 0, 0, 6));
         collect(stall_r, poke, acc, exp_lat);
      end
   endtask

   initial begin
      reset         = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.ld_sel    = 1'b0;
      bus.ld_idx    = '0;
      bus.ld_data   = '0;
      bus.start     = 1'b0;
      bus.res_ready = 1'b1;
      got_first     = '0;
      got_last      = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            expc[i*4 + j] = '0;
            for (int k = 0; k < 4; k++) expc[i*4 + j] += 32'(A_m[i][k] * B_m[k][j]);
         end

      #1;
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
      chk("rst_sa_clr", 32'(bus.sa_clr), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_idx", 32'(bus.res_idx), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_a", 32'(bus.a_out), 32'd0);
      chk("rst_b", 32'(bus.b_out), 32'd0);
`ifdef MM_FEED_CTRL_PERF_EN
      chk("rst_perf", 32'(perf), 32'd0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("idle_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("idle_sa_clr", 32'(bus.sa_clr), 32'd0);
      @(negedge clk);

      load_all();
      run(-1, 1'b1, 1'b0, 28);
      chk("c00_value", got_first, 32'd96);
      chk("c33_value", got_last, 32'd142);
`ifdef MM_FEED_CTRL_PERF_EN
      chk("perf_run1", 32'(perf), 32'd28);
      repeat (3) @(negedge clk);
      chk("perf_hold", 32'(perf), 32'd28);
`endif

      run(7, 1'b0, 1'b0, 33);
      chk("c00_after_poke", got_first, 32'd96);
`ifdef MM_FEED_CTRL_PERF_EN
      chk("perf_stall", 32'(perf), 32'd33);
`endif

      run(-1, 1'b0, 1'b1, 0);
`ifdef MM_FEED_CTRL_PERF_EN
      chk("perf_after_abort", 32'(perf), 32'd0);
`endif
      got_first = '0;
      load_all();
      run(-1, 1'b0, 1'b0, 28);
      chk("c00_restart", got_first, 32'd96);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
